// File: rtl/iter_alu.sv
// ---------------------------------------------------------------------------
// iter_alu -- small integer ALU with a multi-cycle multiply/divide unit.
//
// Single-cycle operations (ADD, SUB, AND, OR, XOR, LSL, LSR, unknown opcodes,
// MUL by zero, DIV by zero) register their result on the accepting edge, so
// done pulses in the following cycle and a new request can be issued every
// cycle. MUL (shift-add) and DIV (restoring) iterate one bit per cycle for
// WIDTH cycles while busy is high. done rises in the first cycle after busy
// falls, and a new request may be accepted on that same edge.
//
// Handshake: a request is accepted on a rising edge where start=1 and
// busy=0. op/rs/rt are sampled only on that edge. A start seen while busy=1
// is dropped, not queued. done is a one-cycle pulse per accepted request.
// rd/rd_hi/div_by_zero hold their value until the next done.
//
// Ports:
//   clk          in   clock, all state updates on the rising edge
//   rst          in   asynchronous active-high reset
//   start        in   request strobe
//   op           in   opcode (0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 LSL,6 LSR,7 MUL,8 DIV)
//   rs           in   first operand / dividend
//   rt           in   second operand / shift amount / divisor
//   busy         out  high while MUL/DIV iterates
//   done         out  one-cycle result-valid pulse
//   rd           out  primary result (sum, low product, quotient, ...)
//   rd_hi        out  secondary result (carry/borrow, high product, remainder)
//   div_by_zero  out  set with done for DIV by zero, cleared otherwise
//   dbg_state_o  out  current FSM state (0 IDLE, 1 RUN)
// ---------------------------------------------------------------------------
module iter_alu #(
    parameter int WIDTH    = 16,
    parameter int OP_WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [OP_WIDTH-1:0] op,
    input  logic [WIDTH-1:0]    rs,
    input  logic [WIDTH-1:0]    rt,
    output logic                busy,
    output logic                done,
    output logic [WIDTH-1:0]    rd,
    output logic [WIDTH-1:0]    rd_hi,
    output logic                div_by_zero,
    output logic                dbg_state_o
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [OP_WIDTH-1:0] OP_ADD = OP_WIDTH'(0);
    localparam logic [OP_WIDTH-1:0] OP_SUB = OP_WIDTH'(1);
    localparam logic [OP_WIDTH-1:0] OP_AND = OP_WIDTH'(2);
    localparam logic [OP_WIDTH-1:0] OP_OR  = OP_WIDTH'(3);
    localparam logic [OP_WIDTH-1:0] OP_XOR = OP_WIDTH'(4);
    localparam logic [OP_WIDTH-1:0] OP_LSL = OP_WIDTH'(5);
    localparam logic [OP_WIDTH-1:0] OP_LSR = OP_WIDTH'(6);
    localparam logic [OP_WIDTH-1:0] OP_MUL = OP_WIDTH'(7);
    localparam logic [OP_WIDTH-1:0] OP_DIV = OP_WIDTH'(8);

    // Counter value seen on the edge that performs the final iteration.
    localparam logic [CNT_W-1:0] LAST_ITER   = CNT_W'(WIDTH - 1);
    // Shift amounts at or above this value flush the operand completely.
    localparam logic [WIDTH-1:0] SHIFT_LIMIT = WIDTH'(WIDTH);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic [WIDTH-1:0]   opa_q, opa_d;    // multiplicand or divisor
    logic [WIDTH-1:0]   acc_q, acc_d;    // product high half or partial remainder
    logic [WIDTH-1:0]   lo_q, lo_d;      // multiplier/product low or dividend/quotient
    logic [WIDTH-1:0]   rd_q, rd_d;
    logic [WIDTH-1:0]   rd_hi_q, rd_hi_d;
    logic               dbz_q, dbz_d;
    logic               done_q, done_d;

    // -----------------------------------------------------------------------
    // Single-cycle datapath (operates on the live inputs)
    // -----------------------------------------------------------------------
    logic [WIDTH:0]     add_full;
    logic [WIDTH:0]     sub_full;
    logic [WIDTH-1:0]   alu_lo;
    logic [WIDTH-1:0]   alu_hi;
    logic               alu_dbz;
    logic               alu_iter;        // request needs the iterative unit

    assign add_full = {1'b0, rs} + {1'b0, rt};
    // Bit WIDTH of the difference is the borrow (set when rs < rt).
    assign sub_full = {1'b0, rs} - {1'b0, rt};

    always_comb begin
        alu_lo   = '0;
        alu_hi   = '0;
        alu_dbz  = 1'b0;
        alu_iter = 1'b0;
        case (op)
            OP_ADD: begin
                alu_lo = add_full[WIDTH-1:0];
                alu_hi = WIDTH'(add_full[WIDTH]);
            end
            OP_SUB: begin
                alu_lo = sub_full[WIDTH-1:0];
                alu_hi = WIDTH'(sub_full[WIDTH]);
            end
            OP_AND: alu_lo = rs & rt;
            OP_OR:  alu_lo = rs | rt;
            OP_XOR: alu_lo = rs ^ rt;
            OP_LSL: begin
                if (rt < SHIFT_LIMIT) alu_lo = rs << rt;
            end
            OP_LSR: begin
                if (rt < SHIFT_LIMIT) alu_lo = rs >> rt;
            end
            OP_MUL: begin
                // A zero multiplier needs no iteration: product is zero.
                alu_iter = (rt != '0);
            end
            OP_DIV: begin
                if (rt == '0) begin
                    alu_lo  = '1;
                    alu_hi  = rs;
                    alu_dbz = 1'b1;
                end else begin
                    alu_iter = 1'b1;
                end
            end
            default: ;  // unknown opcode: zero result
        endcase
    end

    // -----------------------------------------------------------------------
    // One iteration step of each multi-cycle algorithm
    // -----------------------------------------------------------------------
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   mul_acc_n;
    logic [WIDTH-1:0]   mul_lo_n;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_trial;
    logic               div_fits;
    logic [WIDTH-1:0]   div_acc_n;
    logic [WIDTH-1:0]   div_lo_n;

    // Shift-add: add the multiplicand when the current multiplier LSB is
    // set, then shift {carry, acc, lo} right by one. After WIDTH steps
    // {acc, lo} holds the full product.
    assign mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opa_q} : '0);
    assign mul_acc_n = mul_sum[WIDTH:1];
    assign mul_lo_n  = {mul_sum[0], lo_q[WIDTH-1:1]};

    // Restoring division: shift the next dividend bit into the remainder
    // and try subtracting the divisor. The shifted remainder needs WIDTH+1
    // bits; a set top bit of the trial difference means it went negative.
    assign div_shift = {acc_q, lo_q[WIDTH-1]};
    assign div_trial = div_shift - {1'b0, opa_q};
    assign div_fits  = ~div_trial[WIDTH];
    assign div_acc_n = div_fits ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
    assign div_lo_n  = {lo_q[WIDTH-2:0], div_fits};

    // -----------------------------------------------------------------------
    // FSM next-state and datapath control
    // -----------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        opa_d    = opa_q;
        acc_d    = acc_q;
        lo_d     = lo_q;
        rd_d     = rd_q;
        rd_hi_d  = rd_hi_q;
        dbz_d    = dbz_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (alu_iter) begin
                        state_d  = S_RUN;
                        cnt_d    = '0;
                        is_div_d = (op == OP_DIV);
                        acc_d    = '0;
                        if (op == OP_DIV) begin
                            opa_d = rt;
                            lo_d  = rs;
                        end else begin
                            opa_d = rs;
                            lo_d  = rt;
                        end
                    end else begin
                        rd_d    = alu_lo;
                        rd_hi_d = alu_hi;
                        dbz_d   = alu_dbz;
                        done_d  = 1'b1;
                    end
                end
            end
            S_RUN: begin
                acc_d = is_div_q ? div_acc_n : mul_acc_n;
                lo_d  = is_div_q ? div_lo_n  : mul_lo_n;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_ITER) begin
                    // Final step: publish the result straight from the
                    // step logic so done lines up with busy falling.
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    rd_d    = is_div_q ? div_lo_n  : mul_lo_n;
                    rd_hi_d = is_div_q ? div_acc_n : mul_acc_n;
                    dbz_d   = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            opa_q    <= '0;
            acc_q    <= '0;
            lo_q     <= '0;
            rd_q     <= '0;
            rd_hi_q  <= '0;
            dbz_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            opa_q    <= opa_d;
            acc_q    <= acc_d;
            lo_q     <= lo_d;
            rd_q     <= rd_d;
            rd_hi_q  <= rd_hi_d;
            dbz_q    <= dbz_d;
            done_q   <= done_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign busy        = (state_q == S_RUN);
    assign done        = done_q;
    assign rd          = rd_q;
    assign rd_hi       = rd_hi_q;
    assign div_by_zero = dbz_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_iter_alu.sv
module tb_iter_alu;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_LSL = 4'd5;
  localparam logic [3:0] OP_LSR = 4'd6;
  localparam logic [3:0] OP_MUL = 4'd7;
  localparam logic [3:0] OP_DIV = 4'd8;

  typedef struct packed {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] lo;
    logic [15:0] hi;
  } vec_t;

  // Hand-computed single-cycle vectors: op, rs, rt, rd, rd_hi
  localparam vec_t ARITH_V [8] = '{
    '{OP_ADD, 16'h0002, 16'h0000, 16'h0002, 16'h0000},
    '{OP_ADD, 16'h0002, 16'h0003, 16'h0005, 16'h0000},
    '{OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 16'h0001},
    '{OP_SUB, 16'h0005, 16'h0003, 16'h0002, 16'h0000},
    '{OP_SUB, 16'h0000, 16'h0001, 16'hFFFF, 16'h0001},
    '{OP_AND, 16'hF0F0, 16'h3C3C, 16'h3030, 16'h0000},
    '{OP_OR,  16'hF0F0, 16'h3C3C, 16'hFCFC, 16'h0000},
    '{OP_XOR, 16'hF0F0, 16'h3C3C, 16'hCCCC, 16'h0000}
  };

  localparam vec_t SHIFT_V [8] = '{
    '{OP_LSL, 16'h0002, 16'h0003, 16'h0010, 16'h0000},
    '{OP_LSL, 16'h0002, 16'h0000, 16'h0002, 16'h0000},
    '{OP_LSL, 16'h0002, 16'h0010, 16'h0000, 16'h0000},
    '{OP_LSL, 16'h0001, 16'h000F, 16'h8000, 16'h0000},
    '{OP_LSL, 16'hFFFF, 16'h0100, 16'h0000, 16'h0000},
    '{OP_LSR, 16'h8000, 16'h000F, 16'h0001, 16'h0000},
    '{OP_LSR, 16'h8000, 16'h0010, 16'h0000, 16'h0000},
    '{OP_LSR, 16'hFFFF, 16'h0004, 16'h0FFF, 16'h0000}
  };

  localparam vec_t UNK_V [3] = '{
    '{4'd9,   16'h1234, 16'h5678, 16'h0000, 16'h0000},
    '{4'd15,  16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000},
    '{OP_MUL, 16'h1234, 16'h0000, 16'h0000, 16'h0000}
  };

  localparam vec_t MUL_V [2] = '{
    '{OP_MUL, 16'h1234, 16'h0100, 16'h3400, 16'h0012},
    '{OP_MUL, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE}
  };

  localparam vec_t DIV_V [4] = '{
    '{OP_DIV, 16'd100,  16'd7,    16'd14,   16'd2},
    '{OP_DIV, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000},
    '{OP_DIV, 16'd7,    16'd100,  16'd0,    16'd7},
    '{OP_DIV, 16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000}
  };

  // Back-to-back XOR operands and hand-computed results
  localparam logic [15:0] B2B_RS [8] = '{16'h0000, 16'hFFFF, 16'h1234, 16'hAAAA,
                                         16'h00FF, 16'h8001, 16'h0F0F, 16'hDEAD};
  localparam logic [15:0] B2B_RT [8] = '{16'h0000, 16'h0000, 16'h4321, 16'h5555,
                                         16'hFF00, 16'h8001, 16'h00FF, 16'hBEEF};
  localparam logic [15:0] B2B_EX [8] = '{16'h0000, 16'hFFFF, 16'h5115, 16'hFFFF,
                                         16'hFFFF, 16'h0000, 16'h0FF0, 16'h6042};

  logic        clk;
  logic        rst;
  logic        start;
  logic [3:0]  op;
  logic [15:0] rs;
  logic [15:0] rt;
  logic        busy;
  logic        done;
  logic [15:0] rd;
  logic [15:0] rd_hi;
  logic        div_by_zero;
  logic        dbg_state;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];

  iter_alu #(.WIDTH(16), .OP_WIDTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op          (op),
    .rs          (rs),
    .rt          (rt),
    .busy        (busy),
    .done        (done),
    .rd          (rd),
    .rd_hi       (rd_hi),
    .div_by_zero (div_by_zero),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  // Presents one request; returns 1 time unit after the accepting edge.
  task automatic issue(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    op = o;
    rs = a;
    rt = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Observes a multi-cycle run for a fixed cycle budget. Optionally pulses
  // an ADD request while busy and scrambles op/rs/rt afterwards.
  task automatic watch_iter(input int inject_at, output int busy_cnt, output int done_at,
                            output int done_cnt, output logic [15:0] rd_v,
                            output logic [15:0] hi_v, output logic dbz_v);
    busy_cnt = 0;
    done_at  = -1;
    done_cnt = 0;
    rd_v     = '0;
    hi_v     = '0;
    dbz_v    = 1'b0;
    for (int c = 0; c < 24; c++) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at = c;
          rd_v    = rd;
          hi_v    = rd_hi;
          dbz_v   = div_by_zero;
        end
      end
      if (c == inject_at) begin
        start = 1'b1;
        op    = OP_ADD;
        rs    = 16'h0101;
        rt    = 16'h0202;
      end else if (c == inject_at + 1) begin
        start = 1'b0;
        op    = OP_DIV;
        rs    = 16'hFFFF;
        rt    = 16'h0003;
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    op = '0;
    rs = '0;
    rt = '0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0)        begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0)        begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (rd !== 16'h0000)      begin bad++; $display("FAIL reset_rd got=%h exp=0000", rd); end
    total++; if (rd_hi !== 16'h0000)   begin bad++; $display("FAIL reset_rd_hi got=%h exp=0000", rd_hi); end
    total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL reset_dbz got=%b exp=0", div_by_zero); end
    total++; if (dbg_state !== 1'b0)   begin bad++; $display("FAIL reset_state got=%b exp=0", dbg_state); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_arith();
    for (int i = 0; i < 8; i++) begin
      issue(ARITH_V[i].op, ARITH_V[i].a, ARITH_V[i].b);
      total++; if (done !== 1'b1) begin bad++; $display("FAIL arith_done[%0d] got=%b exp=1", i, done); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL arith_busy[%0d] got=%b exp=0", i, busy); end
      total++; if (rd !== ARITH_V[i].lo) begin bad++; $display("FAIL arith_rd[%0d] got=%h exp=%h", i, rd, ARITH_V[i].lo); end
      total++; if (rd_hi !== ARITH_V[i].hi) begin bad++; $display("FAIL arith_rd_hi[%0d] got=%h exp=%h", i, rd_hi, ARITH_V[i].hi); end
      total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL arith_dbz[%0d] got=%b exp=0", i, div_by_zero); end
    end
    // Result holds and done drops when nothing new is issued.
    @(posedge clk);
    #1;
    total++; if (done !== 1'b0) begin bad++; $display("FAIL arith_done_drop got=%b exp=0", done); end
    total++; if (rd !== 16'hCCCC) begin bad++; $display("FAIL arith_hold got=%h exp=cccc", rd); end
  endtask

  task automatic test_shift();
    for (int i = 0; i < 8; i++) begin
      issue(SHIFT_V[i].op, SHIFT_V[i].a, SHIFT_V[i].b);
      total++; if (done !== 1'b1) begin bad++; $display("FAIL shift_done[%0d] got=%b exp=1", i, done); end
      total++; if (rd !== SHIFT_V[i].lo) begin bad++; $display("FAIL shift_rd[%0d] got=%h exp=%h", i, rd, SHIFT_V[i].lo); end
      total++; if (rd_hi !== SHIFT_V[i].hi) begin bad++; $display("FAIL shift_rd_hi[%0d] got=%h exp=%h", i, rd_hi, SHIFT_V[i].hi); end
    end
  endtask

  task automatic test_unknown();
    for (int i = 0; i < 3; i++) begin
      issue(UNK_V[i].op, UNK_V[i].a, UNK_V[i].b);
      total++; if (done !== 1'b1) begin bad++; $display("FAIL unk_done[%0d] got=%b exp=1", i, done); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL unk_busy[%0d] got=%b exp=0", i, busy); end
      total++; if (rd !== UNK_V[i].lo) begin bad++; $display("FAIL unk_rd[%0d] got=%h exp=%h", i, rd, UNK_V[i].lo); end
      total++; if (rd_hi !== UNK_V[i].hi) begin bad++; $display("FAIL unk_rd_hi[%0d] got=%h exp=%h", i, rd_hi, UNK_V[i].hi); end
    end
  endtask

  task automatic test_mul();
    int bc, da, dc;
    logic [15:0] rv, hv;
    logic dz;
    for (int i = 0; i < 2; i++) begin
      issue(MUL_V[i].op, MUL_V[i].a, MUL_V[i].b);
      total++; if (dbg_state !== 1'b1) begin bad++; $display("FAIL mul_state[%0d] got=%b exp=1", i, dbg_state); end
      watch_iter((i == 0) ? 4 : -10, bc, da, dc, rv, hv, dz);
      total++; if (bc !== 16) begin bad++; $display("FAIL mul_busy_cycles[%0d] got=%0d exp=16", i, bc); end
      total++; if (da !== 16) begin bad++; $display("FAIL mul_done_cycle[%0d] got=%0d exp=16", i, da); end
      total++; if (dc !== 1) begin bad++; $display("FAIL mul_done_count[%0d] got=%0d exp=1", i, dc); end
      total++; if (rv !== MUL_V[i].lo) begin bad++; $display("FAIL mul_rd[%0d] got=%h exp=%h", i, rv, MUL_V[i].lo); end
      total++; if (hv !== MUL_V[i].hi) begin bad++; $display("FAIL mul_rd_hi[%0d] got=%h exp=%h", i, hv, MUL_V[i].hi); end
      total++; if (dz !== 1'b0) begin bad++; $display("FAIL mul_dbz[%0d] got=%b exp=0", i, dz); end
      total++; if (rd !== MUL_V[i].lo) begin bad++; $display("FAIL mul_hold[%0d] got=%h exp=%h", i, rd, MUL_V[i].lo); end
    end
  endtask

  task automatic test_div();
    int bc, da, dc;
    logic [15:0] rv, hv;
    logic dz;
    for (int i = 0; i < 4; i++) begin
      issue(DIV_V[i].op, DIV_V[i].a, DIV_V[i].b);
      watch_iter((i == 0) ? 7 : -10, bc, da, dc, rv, hv, dz);
      total++; if (bc !== 16) begin bad++; $display("FAIL div_busy_cycles[%0d] got=%0d exp=16", i, bc); end
      total++; if (da !== 16) begin bad++; $display("FAIL div_done_cycle[%0d] got=%0d exp=16", i, da); end
      total++; if (dc !== 1) begin bad++; $display("FAIL div_done_count[%0d] got=%0d exp=1", i, dc); end
      total++; if (rv !== DIV_V[i].lo) begin bad++; $display("FAIL div_quot[%0d] got=%h exp=%h", i, rv, DIV_V[i].lo); end
      total++; if (hv !== DIV_V[i].hi) begin bad++; $display("FAIL div_rem[%0d] got=%h exp=%h", i, hv, DIV_V[i].hi); end
      total++; if (dz !== 1'b0) begin bad++; $display("FAIL div_dbz[%0d] got=%b exp=0", i, dz); end
    end
    issue(OP_DIV, 16'd5, 16'd0);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL div0_done got=%b exp=1", done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL div0_busy got=%b exp=0", busy); end
    total++; if (rd !== 16'hFFFF) begin bad++; $display("FAIL div0_rd got=%h exp=ffff", rd); end
    total++; if (rd_hi !== 16'h0005) begin bad++; $display("FAIL div0_rd_hi got=%h exp=0005", rd_hi); end
    total++; if (div_by_zero !== 1'b1) begin bad++; $display("FAIL div0_dbz got=%b exp=1", div_by_zero); end
    issue(OP_ADD, 16'h0001, 16'h0001);
    total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL div0_dbz_clear got=%b exp=0", div_by_zero); end
    total++; if (rd !== 16'h0002) begin bad++; $display("FAIL div0_next_rd got=%h exp=0002", rd); end
  endtask

  task automatic test_reset_run();
    int dc;
    // Leave non-zero outputs behind so the reset clear is visible.
    issue(OP_DIV, 16'd9, 16'd0);
    total++; if (div_by_zero !== 1'b1) begin bad++; $display("FAIL rrun_setup_dbz got=%b exp=1", div_by_zero); end
    issue(OP_MUL, 16'h1234, 16'h0100);
    repeat (5) @(posedge clk);
    #1;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rrun_busy_before got=%b exp=1", busy); end
    #2;
    rst = 1'b1;
    #1;
    total++; if (busy !== 1'b0)        begin bad++; $display("FAIL rrun_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0)        begin bad++; $display("FAIL rrun_done got=%b exp=0", done); end
    total++; if (rd !== 16'h0000)      begin bad++; $display("FAIL rrun_rd got=%h exp=0000", rd); end
    total++; if (rd_hi !== 16'h0000)   begin bad++; $display("FAIL rrun_rd_hi got=%h exp=0000", rd_hi); end
    total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL rrun_dbz got=%b exp=0", div_by_zero); end
    total++; if (dbg_state !== 1'b0)   begin bad++; $display("FAIL rrun_state got=%b exp=0", dbg_state); end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    dc = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (done) dc++;
    end
    total++; if (dc !== 0) begin bad++; $display("FAIL rrun_no_done got=%0d exp=0", dc); end
    issue(OP_SUB, 16'd3, 16'd5);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL rrun_sub_done got=%b exp=1", done); end
    total++; if (rd !== 16'hFFFE) begin bad++; $display("FAIL rrun_sub_rd got=%h exp=fffe", rd); end
    total++; if (rd_hi !== 16'h0001) begin bad++; $display("FAIL rrun_sub_rd_hi got=%h exp=0001", rd_hi); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] e;
    exp_q.delete();
    @(negedge clk);
    op = OP_XOR;
    rs = B2B_RS[0];
    rt = B2B_RT[0];
    start = 1'b1;
    exp_q.push_back(B2B_EX[0]);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      total++;
      if (done !== 1'b1) begin
        bad++; $display("FAIL b2b_done[%0d] got=%b exp=1", i, done);
      end else if (exp_q.size() == 0) begin
        bad++; $display("FAIL b2b_queue[%0d] got=empty exp=entry", i);
      end else begin
        e = exp_q.pop_front();
        if (rd !== e) begin bad++; $display("FAIL b2b_rd[%0d] got=%h exp=%h", i, rd, e); end
      end
      if (i < 7) begin
        rs = B2B_RS[i+1];
        rt = B2B_RT[i+1];
        exp_q.push_back(B2B_EX[i+1]);
      end else begin
        start = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    total++; if (done !== 1'b0) begin bad++; $display("FAIL b2b_done_end got=%b exp=0", done); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL b2b_leftover got=%0d exp=0", exp_q.size()); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_arith();
    test_shift();
    test_unknown();
    test_mul();
    test_div();
    test_reset_run();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/iter_alu.md
ITER_ALU -- requirements
Module: iter_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width in bits (min 4, power of two).
REQ-002 SHALL have parameter OP_WIDTH, default 4, opcode width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request; op/rs/rt sampled on the edge where start=1 and busy=0.
REQ-006 SHALL have port op  input  OP_WIDTH  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 LSL, 6 LSR, 7 MUL, 8 DIV.
REQ-007 SHALL have port rs  input  WIDTH  first operand.
REQ-008 SHALL have port rt  input  WIDTH  second operand / shift amount / divisor.
REQ-009 SHALL have port busy  output  1  high while a MUL/DIV iteration is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse marking rd/rd_hi/div_by_zero valid.
REQ-011 SHALL have port rd  output  WIDTH  primary result.
REQ-012 SHALL have port rd_hi  output  WIDTH  secondary result (carry, MUL high half, DIV remainder).
REQ-013 SHALL have port div_by_zero  output  1  flag, valid with done.

Function
REQ-014 SHALL implement FSM IDLE/RUN; IDLE->RUN on accepted MUL/DIV with rt!=0; RUN->IDLE on final iteration edge.
REQ-015 SHALL assert busy exactly while in RUN; start while busy=1 SHALL be ignored, not queued.
REQ-016 Single-cycle ops (0-6, unknown, DIV by zero) SHALL register results on the accepting edge: done=1 the following cycle, latency 1, back-to-back issue every cycle allowed.
REQ-017 ADD: rd=(rs+rt) mod 2^WIDTH, rd_hi={0..0,carry}; SUB: rd=(rs-rt) mod 2^WIDTH, rd_hi={0..0,borrow}.
REQ-018 AND/OR/XOR: bitwise on rd, rd_hi=0.
REQ-019 LSL/LSR: logical shift of rs by unsigned rt; rt>=WIDTH SHALL give rd=0; rd_hi=0.
REQ-020 MUL: unsigned shift-add, one bit per cycle, WIDTH iterations; {rd_hi,rd}=rs*rt (2*WIDTH bits).
REQ-021 DIV: unsigned restoring, one quotient bit per cycle, WIDTH iterations; rd=quotient, rd_hi=remainder.
REQ-022 DIV with rt=0 SHALL take single-cycle path: rd=all ones, rd_hi=rs, div_by_zero=1; div_by_zero=0 for every other result.
REQ-023 MUL/DIV: busy=1 for exactly WIDTH cycles after the accepting edge; done=1 in the cycle after busy falls; start may be accepted on the edge where busy is observed 0.
REQ-024 Unknown opcodes (9..2^OP_WIDTH-1) SHALL give rd=0, rd_hi=0, done after 1 cycle.
REQ-025 Operands SHALL be latched at acceptance; rs/rt/op changes during RUN SHALL not affect the result.
REQ-026 rd, rd_hi, div_by_zero SHALL hold their last value until the next done; done SHALL never be high two cycles for one request.
REQ-027 Iteration counter SHALL be $clog2(WIDTH)+1 bits, no wrap-around aliasing.

Reset
REQ-028 rst=1 SHALL immediately (asynchronously) force state IDLE, busy=0, done=0, rd=0, rd_hi=0, div_by_zero=0, counter=0.
REQ-029 Reset during RUN SHALL abort the operation with no done pulse; first start after rst release SHALL behave normally.

Verification (WIDTH=16)
REQ-030 ADD rs=2 rt=0 -> rd=2; then rs=2 rt=3 -> rd=5, rd_hi=0; rs=0xFFFF rt=1 -> rd=0, rd_hi=1; done 1 cycle after each start.
REQ-031 LSL rs=2 rt=3 -> rd=0x10; rt=0 -> rd=0x2; rt=16 -> rd=0; LSR rs=0x8000 rt=15 -> rd=1.
REQ-032 MUL rs=0x1234 rt=0x0100 -> busy 16 cycles, then done with rd=0x3400, rd_hi=0x0012; ADD start pulsed mid-busy -> ignored, no extra done.
REQ-033 DIV rs=100 rt=7 -> rd=14, rd_hi=2, div_by_zero=0 after 16 busy cycles; DIV rs=5 rt=0 -> rd=0xFFFF, rd_hi=5, div_by_zero=1, latency 1.
REQ-034 MUL started, rst asserted after 5 cycles -> all outputs 0 at once, no done; subsequent SUB rs=3 rt=5 -> rd=0xFFFE, rd_hi=1.
REQ-035 Back-to-back XOR each cycle for 8 cycles -> 8 consecutive done pulses, each rd matching its own operands.
